// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-back arbiter.
// Pipeline (MEM stage) writes take absolute priority. Completed multi-cycle
// MDU results wait in a 2-entry FIFO and drain into pipeline bubbles.
// busy_vec tracks destinations with an MDU write still outstanding.
// Optional feature macro: WB_LOAD_EXT_EN (load byte/halfword extraction and
// sign/zero extension). Without it, load data is written as the raw word.
module wb_arbiter (
  input  logic        clk_cpu,
  input  logic        rst_cpu,
  input  logic        mem_valid,
  input  logic        mem_rd_we,
  input  logic [4:0]  mem_rd,
  input  logic        mem_is_load,
  input  logic [2:0]  mem_funct3,
  input  logic [1:0]  mem_addr_lo,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_load_data,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_rd,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rd_we_wb,
  output logic [4:0]  rd_wb,
  output logic [31:0] data_wb,
  output logic [31:0] busy_vec
);

`ifdef WB_LOAD_EXT_EN
  // Select the addressed byte/halfword of the memory word and extend it.
  function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] word);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    byte_v = word[{off, 3'b000} +: 8];
    half_v = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  res_v = {{16{half_v[15]}}, half_v};
      3'b010:  res_v = word;
      3'b100:  res_v = {24'd0, byte_v};
      3'b101:  res_v = {16'd0, half_v};
      default: res_v = word;
    endcase
    load_ext = res_v;
  endfunction
`else
  // Width/offset are irrelevant when loads are written as whole words.
  logic unused_cfg_s;
  assign unused_cfg_s = ^{mem_funct3, mem_addr_lo};
`endif

  logic        pipe_wr_s;
  logic [31:0] pipe_data_s;
  logic        push_s;
  logic        pop_s;

  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0][4:0]  fifo_rd_q;
  logic [1:0][31:0] fifo_data_q;
  logic [4:0]       head_rd_s;
  logic [31:0]      head_data_s;

  logic        rd_we_q, rd_we_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic [31:0] busy_q, busy_d;

  // Pipeline write qualification and write-data selection.
  always_comb begin
    pipe_wr_s = mem_valid && mem_rd_we && (mem_rd != 5'd0);
    if (mem_is_load) begin
`ifdef WB_LOAD_EXT_EN
      pipe_data_s = load_ext(mem_funct3, mem_addr_lo, mem_load_data);
`else
      pipe_data_s = mem_load_data;
`endif
    end else begin
      pipe_data_s = mem_alu_result;
    end
  end

  // FIFO handshake: ready depends on occupancy only; x0 results are dropped
  // without occupying a slot; pop only from entries present at cycle start.
  always_comb begin
    mdu_ready   = (count_q < 2'd2);
    push_s      = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
    pop_s       = !pipe_wr_s && (count_q != 2'd0);
    head_rd_s   = fifo_rd_q[rd_ptr_q];
    head_data_s = fifo_data_q[rd_ptr_q];
  end

  // FIFO occupancy and pointer next-state (pointers wrap modulo 2).
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (push_s) begin
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Write-port next-state: pipeline first, then FIFO head, else idle (hold).
  always_comb begin
    rd_we_d = 1'b0;
    rd_d    = rd_q;
    data_d  = data_q;
    if (pipe_wr_s) begin
      rd_we_d = 1'b1;
      rd_d    = mem_rd;
      data_d  = pipe_data_s;
    end else if (pop_s) begin
      rd_we_d = 1'b1;
      rd_d    = head_rd_s;
      data_d  = head_data_s;
    end else begin
      rd_we_d = 1'b0;
    end
  end

  // Pending-write scoreboard: clear on drain, then set on issue so set wins.
  always_comb begin
    busy_d = busy_q;
    if (pop_s) begin
      busy_d[head_rd_s] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (mdu_issue && (mdu_issue_rd != 5'd0)) begin
      busy_d[mdu_issue_rd] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Control state: FIFO bookkeeping, write port and scoreboard.
  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      rd_we_q  <= 1'b0;
      rd_q     <= 5'd0;
      data_q   <= 32'd0;
      busy_q   <= 32'd0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rd_we_q  <= rd_we_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
    end
  end

  // FIFO storage: capture an accepted result at the write pointer.
  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      fifo_rd_q   <= '0;
      fifo_data_q <= '0;
    end else if (push_s) begin
      fifo_rd_q[wr_ptr_q]   <= mdu_rd;
      fifo_data_q[wr_ptr_q] <= mdu_data;
    end else begin
      fifo_rd_q   <= fifo_rd_q;
      fifo_data_q <= fifo_data_q;
    end
  end

  assign rd_we_wb = rd_we_q;
  assign rd_wb    = rd_q;
  assign data_wb  = data_q;
  assign busy_vec = busy_q;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have port clk_cpu, input, 1, the only clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_cpu, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port mem_valid, input, 1, MEM stage holds a valid instruction this cycle.
REQ-004 SHALL have port mem_rd_we, input, 1, that instruction writes a destination register.
REQ-005 SHALL have port mem_rd, input, 5, destination register index.
REQ-006 SHALL have port mem_is_load, input, 1, the result comes from memory, not the ALU.
REQ-007 SHALL have port mem_funct3, input, 3, load width/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
REQ-008 SHALL have port mem_addr_lo, input, 2, byte offset of the load address.
REQ-009 SHALL have port mem_alu_result, input, 32, ALU or link result.
REQ-010 SHALL have port mem_load_data, input, 32, raw aligned memory word.
REQ-011 SHALL have port mdu_issue, input, 1, a multi-cycle mul/div op is issued this cycle.
REQ-012 SHALL have port mdu_issue_rd, input, 5, destination of the issued op.
REQ-013 SHALL have port mdu_valid, input, 1, the MDU offers a completed result.
REQ-014 SHALL have port mdu_rd, input, 5, destination index of the offered result.
REQ-015 SHALL have port mdu_data, input, 32, the offered result.
REQ-016 SHALL have port mdu_ready, output, 1, the MDU result is accepted this cycle.
REQ-017 SHALL have port rd_we_wb, output, 1, register-file write enable.
REQ-018 SHALL have port rd_wb, output, 5, register-file write index.
REQ-019 SHALL have port data_wb, output, 32, register-file write data.
REQ-020 SHALL have port busy_vec, output, 32, per-register pending-MDU-write flags for the hazard unit.

Function
REQ-021 SHALL register rd_we_wb, rd_wb and data_wb, so every output write is held for exactly one cycle.
REQ-022 SHALL treat a pipeline write as valid when mem_valid=1, mem_rd_we=1 and mem_rd!=0.
- A valid pipeline write appears on the write port on the next rising edge (latency 1).
- Pipeline writes have absolute priority.
REQ-023 SHALL buffer MDU results in a 2-entry FIFO.
- mdu_ready = (count<2), combinational from the count only.
- A result is accepted when mdu_valid && mdu_ready.
- A result with mdu_rd=0 is accepted and discarded.
REQ-024 SHALL, when no valid pipeline write exists, pop the FIFO head to the write port on the next edge.
- Otherwise rd_we_wb=0 next cycle; rd_wb and data_wb then hold their previous values.
REQ-025 SHALL allow accept and pop in the same cycle.
- Count is unchanged.
- An accept into an empty FIFO is not popped in that cycle (minimum MDU latency 1 cycle after accept).
- Pointers wrap modulo 2.
REQ-026 SHALL set busy_vec[mdu_issue_rd] on mdu_issue when mdu_issue_rd!=0.
- SHALL clear the bit on the edge the matching FIFO entry is driven on the write port.
- If set and clear hit the same index in one cycle, set wins.
- busy_vec[0] is constantly 0.
REQ-027 SHALL never assert rd_we_wb with rd_wb=0.

Reset
REQ-028 SHALL, while rst_cpu=1, force the following at once, independent of clk_cpu:
- rd_we_wb=0, rd_wb=0, data_wb=0;
- FIFO empty and both pointers 0;
- busy_vec=0 and mdu_ready=1.
REQ-029 SHALL discard in-flight FIFO entries on a reset mid-operation; no partial write is emitted after release.

Configuration
REQ-030 SHALL support macro WB_LOAD_EXT_EN.
- When defined, a load's data_wb is the byte/halfword of mem_load_data selected by mem_addr_lo, sign- or zero-extended per mem_funct3.
- A halfword uses offsets 0 or 2.
- Undefined funct3 values pass the word through.
REQ-031 SHALL, when WB_LOAD_EXT_EN is undefined, write mem_load_data unmodified for loads and ignore mem_funct3 and mem_addr_lo.

Verification
REQ-032 SHALL cover pipeline ALU write: mem_rd=5, mem_alu_result=0x1234 -> next cycle rd_we_wb=1, rd_wb=5, data_wb=0x1234; the following idle cycle rd_we_wb=0.
REQ-033 SHALL cover load extension with the macro on: lb, offset 3, word 0x80FF0011 -> data_wb=0xFFFFFF80; lhu, offset 2 -> 0x000080FF.
REQ-034 SHALL cover a conflict: pipeline writes x3 each cycle while an MDU result for x7 is offered.
- x7 is accepted but not written until the first pipeline bubble.
- It is then written one cycle later with the correct data.
REQ-035 SHALL cover FIFO full: three consecutive MDU results with pipeline writes blocking -> mdu_ready=0 after two accepts; the third is taken once a pop occurs.
REQ-036 SHALL cover the scoreboard: issue x9 -> busy_vec[9]=1 until x9's write cycle.
- A re-issue of x9 on that same cycle keeps the bit at 1.
- Issue x0 -> busy_vec unchanged.
REQ-037 SHALL cover async reset asserted with 2 FIFO entries -> outputs 0 without a clock edge; after release no stale write appears.
